pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer for the multi-cycle microcontroller. It replaces the fixed-width PC/increment/skip path with a configurable-width PC, conditional jumps and skips on the ALU zero and carry flags, and a hardware return-address stack of configurable depth for CALL/RET. It sits between the control unit, which supplies `op`, `en` and `target`, and the program memory, which is addressed by `pc`.

## Interface
Parameters:
- `PC_W`, default 10: program counter width in bits; program memory holds 2^PC_W words.
- `STACK_D`, default 4: return-stack depth in entries, with STACK_D >= 1.
- `SP_W`, default `$clog2(STACK_D+1)`: width of the stack occupancy count.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `en`  in  1  advance enable; when 0, all state holds (stall).
- `op`  in  3  sequencing operation, decoded below.
- `target`  in  PC_W  jump/call destination from the instruction immediate field.
- `zero`  in  1  ALU zero flag, already registered by the datapath.
- `carry`  in  1  ALU carry flag, already registered by the datapath.
- `clr_err`  in  1  clears the sticky error flags.
- `pc`  out  PC_W  current program counter (registered).
- `npc`  out  PC_W  combinational next-PC value, for prefetch.
- `sp`  out  SP_W  number of valid stack entries, 0..STACK_D.
- `stack_empty`  out  1  high when `sp` = 0.
- `stack_full`  out  1  high when `sp` = STACK_D.
- `overflow`  out  1  sticky; set by a CALL issued while the stack is full.
- `underflow`  out  1  sticky; set by a RET issued while the stack is empty.

## Operation
- Let `inc` = `pc`+1 and `inc2` = `pc`+2. Both wrap modulo 2^PC_W; there is no carry-out and no error on wrap.
- `op` decode, giving `npc`:
  - 000 INC: `npc` = `inc`.
  - 001 JMP: `npc` = `target`.
  - 010 JZ: `npc` = `target` if `zero`, else `inc`.
  - 011 JC: `npc` = `target` if `carry`, else `inc`.
  - 100 CALL:
    - If not full: push `inc`, then `npc` = `target`.
    - If full: no push, `npc` = `inc`, set `overflow`.
  - 101 RET:
    - If not empty: pop the top entry; `npc` = that entry.
    - If empty: `npc` = `inc`, set `underflow`.
  - 110 SKZ: `npc` = `inc2` if `zero`, else `inc`.
  - 111 HOLD: `npc` = `pc`; the stack is unchanged.
- Stack:
  - LIFO register array of STACK_D × PC_W bits.
  - Push writes `stack[sp]` and increments `sp`.
  - Pop reads `stack[sp-1]` and decrements `sp`.
  - Entries at index >= `sp` are don't-care.
- Error flags:
  - `overflow` and `underflow` stay set until `clr_err`=1 or reset.
  - If a set event and `clr_err` occur in the same cycle, the set wins.
  - `clr_err` acts regardless of `en`.
- Stall: with `en`=0, `pc`, `sp`, the stack contents and the error flags other than `clr_err` effects all hold. `npc` still reflects the decode of the current inputs.
- Reset (`reset`=0 at a rising edge) takes priority over `en`, `op` and `clr_err`:
  - `pc` = 0, `sp` = 0, `overflow` = 0, `underflow` = 0.
  - Stack contents are not cleared.
  - Reset mid-sequence (for example, after pending CALLs) discards all return addresses.
- Output values under reset: `pc`=0, `sp`=0, `stack_empty`=1, `stack_full`=0, `overflow`=0, `underflow`=0. `npc` is combinational; with `op`=INC it reads 1.

## Timing
- Single clock domain, fully synchronous.
- One-cycle latency: `op`, `target`, `zero` and `carry` sampled at edge N produce the new `pc` and `sp` in the cycle after edge N.
- `npc` is a combinational function of `pc`, `op`, `target`, `zero`, `carry` and the stack top, with no register in the path. The control unit must hold its inputs stable across the sampling edge.
- `stack_empty` and `stack_full` are decoded from registered `sp`, so they are glitch-free and valid one cycle after the CALL/RET that changed `sp`.
- Back-to-back operations are allowed on every enabled cycle, for example CALL followed immediately by RET. A RET in the cycle after a CALL returns the address pushed by that CALL.
- `overflow` and `underflow` assert in the same cycle that the offending `pc` update becomes visible.

## Test plan
- Reset and increment: hold `reset`=0 for 2 edges, then release with `op`=INC and `en`=1 for 5 cycles. `pc` must read 0,1,2,3,4,5; `sp`=0; `stack_empty`=1.
- Conditional flow:
  - At `pc`=5, JZ with `target`=0x040 and `zero`=0 gives `pc`=6.
  - JZ with `zero`=1 gives `pc`=0x040.
  - SKZ with `zero`=1 gives `pc`=0x042.
  - JC with `carry`=1 and `target`=0x3FF gives `pc`=0x3FF.
  - INC then gives `pc`=0x000 (wrap).
- Nested calls, with `PC_W`=10 and `STACK_D`=4:
  - CALL from `pc`=0x010 to 0x100, then from 0x100 to 0x200, then from 0x200 to 0x300. `sp` must read 1,2,3.
  - Three RETs must give `pc` = 0x201, 0x101, 0x011, with `sp` back to 0.
- Overflow: five CALLs in a row starting at `pc`=0, each with `target`=0x080.
  - After the 4th CALL: `stack_full`=1.
  - 5th CALL: `pc`=0x081, `sp`=4, `overflow`=1.
  - `overflow` stays 1 until `clr_err`=1 for one cycle.
- Underflow and stall:
  - RET with `sp`=0 at `pc`=7 gives `pc`=8, `underflow`=1.
  - Then `en`=0 for 3 cycles with `op`=JMP: `pc` holds at 8.
- Reset mid-operation: after two CALLs (`sp`=2), drive `reset`=0 for one edge. `pc`=0 and `sp`=0. A following RET must set `underflow`=1 and give `pc`=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: configurable-width PC with conditional jumps/skips on
// the ALU flags and a hardware return-address stack for CALL/RET.
module pc_sequencer #(
  parameter int PC_W    = 10,
  parameter int STACK_D = 4,
  parameter int SP_W    = $clog2(STACK_D + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [2:0]      op,
  input  logic [PC_W-1:0] target,
  input  logic            zero,
  input  logic            carry,
  input  logic            clr_err,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] npc,
  output logic [SP_W-1:0] sp,
  output logic            stack_empty,
  output logic            stack_full,
  output logic            overflow,
  output logic            underflow
);

  typedef enum logic [2:0] {
    OP_INC  = 3'b000,
    OP_JMP  = 3'b001,
    OP_JZ   = 3'b010,
    OP_JC   = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101,
    OP_SKZ  = 3'b110,
    OP_HOLD = 3'b111
  } op_e;

  logic [STACK_D-1:0][PC_W-1:0] stack;
  logic [PC_W-1:0] inc, inc2, top;
  logic push, pop, ovf_set, unf_set;

  assign inc         = pc + PC_W'(1);
  assign inc2        = pc + PC_W'(2);
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SP_W'(STACK_D));

  // Top of stack is entry sp-1; matching i+1 against sp avoids an sp-1 underflow at sp=0.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_D; i++)
      if (SP_W'(i + 1) == sp) top = stack[i];
  end

  always_comb begin
    npc     = inc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op_e'(op))
      OP_INC:  npc = inc;
      OP_JMP:  npc = target;
      OP_JZ:   npc = zero  ? target : inc;
      OP_JC:   npc = carry ? target : inc;
      OP_CALL: begin
        if (stack_full) ovf_set = 1'b1;
        else begin
          push = 1'b1;
          npc  = target;
        end
      end
      OP_RET: begin
        if (stack_empty) unf_set = 1'b1;
        else begin
          pop = 1'b1;
          npc = top;
        end
      end
      OP_SKZ:  npc = zero ? inc2 : inc;
      OP_HOLD: npc = pc;
      default: npc = inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc        <= '0;
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (en) begin
        pc <= npc;
        if (push)     sp <= sp + SP_W'(1);
        else if (pop) sp <= sp - SP_W'(1);
      end
      // clr_err works even while stalled; a same-cycle set still wins
      overflow  <= (en & ovf_set) | (overflow  & ~clr_err);
      underflow <= (en & unf_set) | (underflow & ~clr_err);
    end
  end

  // Stack storage carries no reset; entries at or above sp are dead data.
  always_ff @(posedge clk) begin
    if (reset && en && push)
      for (int i = 0; i < STACK_D; i++)
        if (SP_W'(i) == sp) stack[i] <= inc;
  end

endmodule
